// File: rtl/jogo_memoria_pkg.sv
// Shared definitions for the parametrised memory game: 5-bit FSM state
// codes (visible on db_estado) and the play-mode encodings.
package jogo_memoria_pkg;

    localparam int unsigned ESTADO_W = 5;

    typedef enum logic [ESTADO_W-1:0] {
        INICIAL       = 5'd0,
        PREPARA       = 5'd1,
        MOSTRA_LED    = 5'd2,
        APAGA_LED     = 5'd3,
        PROX_LED      = 5'd4,
        ESPERA_JOGADA = 5'd5,
        COMPARA       = 5'd6,
        PROX_JOGADA   = 5'd7,
        ESCRITA       = 5'd8,
        PROX_RODADA   = 5'd9,
        FIM_GANHOU    = 5'd10,
        FIM_PERDEU    = 5'd11,
        FIM_TIMEOUT   = 5'd12
    } estado_t;

    localparam logic [1:0] MODO_NORMAL      = 2'b00;
    localparam logic [1:0] MODO_DEMO        = 2'b01;
    localparam logic [1:0] MODO_SEM_TIMEOUT = 2'b10;
    localparam logic [1:0] MODO_ESCRITA     = 2'b11;

endpackage

// File: rtl/jogo_memoria_param_if.sv
// Player/board-side bundle of the memory game.
//   jogar, configuracao, botoes : inputs from the board (master drives)
//   leds, pronto, ganhou, perdeu, timeout, db_* : game outputs (slave drives)
interface jogo_memoria_param_if #(
    parameter int unsigned N_BOTOES    = 4,
    parameter int unsigned MAX_RODADAS = 16
);
    localparam int unsigned RW = $clog2(MAX_RODADAS) + 1;

    logic                jogar;
    logic [1:0]          configuracao;
    logic [N_BOTOES-1:0] botoes;
    logic [N_BOTOES-1:0] leds;
    logic                pronto;
    logic                ganhou;
    logic                perdeu;
    logic                timeout;
    logic [4:0]          db_estado;
    logic [RW-1:0]       db_rodada;
    logic [1:0]          db_modo;

    modport master (
        output jogar, configuracao, botoes,
        input  leds, pronto, ganhou, perdeu, timeout, db_estado, db_rodada, db_modo
    );

    modport slave (
        input  jogar, configuracao, botoes,
        output leds, pronto, ganhou, perdeu, timeout, db_estado, db_rodada, db_modo
    );

endinterface

// File: rtl/jogo_memoria_uc.sv
// Control FSM of the memory game. Consumes status flags from the datapath
// and returns the current state plus the combinational next state, which
// the datapath uses to load its registered outputs and counters.
//   clock, reset (async, active-low), jogar, press, press_unico, acertou,
//   fim_seq, ultima_rodada, modo_escrita, fim_on, fim_off, fim_tmo
//   estado (registered), prox_estado_c (combinational)
module jogo_memoria_uc
    import jogo_memoria_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    input  logic    jogar,
    input  logic    press,
    input  logic    press_unico,
    input  logic    acertou,
    input  logic    fim_seq,
    input  logic    ultima_rodada,
    input  logic    modo_escrita,
    input  logic    fim_on,
    input  logic    fim_off,
    input  logic    fim_tmo,
    output estado_t estado,
    output estado_t prox_estado_c
);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= INICIAL;
        else        estado <= prox_estado_c;
    end

    // Next-state logic; a press in the same cycle as timeout expiry wins
    always_comb begin
        prox_estado_c = estado;
        case (estado)
            INICIAL:       if (jogar) prox_estado_c = PREPARA;
            PREPARA:       prox_estado_c = MOSTRA_LED;
            MOSTRA_LED:    if (fim_on) prox_estado_c = APAGA_LED;
            APAGA_LED:     if (fim_off) prox_estado_c = PROX_LED;
            PROX_LED:      prox_estado_c = fim_seq ? ESPERA_JOGADA : MOSTRA_LED;
            ESPERA_JOGADA: begin
                if (press)        prox_estado_c = COMPARA;
                else if (fim_tmo) prox_estado_c = FIM_TIMEOUT;
            end
            COMPARA: begin
                if (!acertou)          prox_estado_c = FIM_PERDEU;
                else if (!fim_seq)     prox_estado_c = PROX_JOGADA;
                else if (ultima_rodada) prox_estado_c = FIM_GANHOU;
                else if (modo_escrita) prox_estado_c = ESCRITA;
                else                   prox_estado_c = PROX_RODADA;
            end
            PROX_JOGADA:   prox_estado_c = ESPERA_JOGADA;
            ESCRITA: begin
                if (press)        prox_estado_c = press_unico ? PROX_RODADA : FIM_PERDEU;
                else if (fim_tmo) prox_estado_c = FIM_TIMEOUT;
            end
            PROX_RODADA:   prox_estado_c = MOSTRA_LED;
            FIM_GANHOU,
            FIM_PERDEU,
            FIM_TIMEOUT:   if (jogar) prox_estado_c = PREPARA;
            default:       prox_estado_c = INICIAL;
        endcase
    end

endmodule

// File: rtl/jogo_memoria_param.sv
// Parametrised memory-game engine: sequence memory, round/address counters,
// press edge detector, shared LED/timeout timer and registered (Moore) outputs.
//   clock, reset (async, active-low)
//   bus (slave): jogar, configuracao, botoes in; leds, pronto, ganhou,
//                perdeu, timeout, db_estado, db_rodada, db_modo out
module jogo_memoria_param
    import jogo_memoria_pkg::*;
#(
    parameter int unsigned N_BOTOES       = 4,
    parameter int unsigned MAX_RODADAS    = 16,
    parameter int unsigned RODADAS_DEMO   = 4,
    parameter int unsigned LED_ON         = 500,
    parameter int unsigned LED_OFF        = 250,
    parameter int unsigned TIMEOUT_CICLOS = 5000
) (
    input  logic                  clock,
    input  logic                  reset,
    jogo_memoria_param_if.slave   bus
);

    localparam int unsigned BW   = $clog2(N_BOTOES);
    localparam int unsigned AW   = $clog2(MAX_RODADAS);
    localparam int unsigned RW   = AW + 1;
    localparam int unsigned T1   = (LED_ON > LED_OFF) ? LED_ON : LED_OFF;
    localparam int unsigned TMAX = (TIMEOUT_CICLOS > T1) ? TIMEOUT_CICLOS : T1;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    estado_t             estado, prox_c;
    logic [1:0]          modo;
    logic [BW-1:0]       mem [MAX_RODADAS];
    logic [RW-1:0]       rodada, rodada_prox_c;
    logic [AW-1:0]       endereco, endereco_prox_c;
    logic [N_BOTOES-1:0] botoes_q, press_val_q, jogada, leds_q;
    logic                press_q;
    logic [TW-1:0]       tmr;
    logic                pronto_q, ganhou_q, perdeu_q, timeout_q;
    logic                press_unico_c, acertou_c, fim_seq_c, ultima_c, escrita_c;
    logic                fim_on_c, fim_off_c, fim_tmo_c;
    logic [RW-1:0]       limite_c;

    // One-hot to index (highest set bit wins; callers check $onehot separately)
    function automatic logic [BW-1:0] codifica(input logic [N_BOTOES-1:0] v);
        codifica = '0;
        for (int i = 0; i < int'(N_BOTOES); i++)
            if (v[i]) codifica = BW'(i);
    endfunction

    jogo_memoria_uc u_uc (
        .clock         (clock),
        .reset         (reset),
        .jogar         (bus.jogar),
        .press         (press_q),
        .press_unico   (press_unico_c),
        .acertou       (acertou_c),
        .fim_seq       (fim_seq_c),
        .ultima_rodada (ultima_c),
        .modo_escrita  (escrita_c),
        .fim_on        (fim_on_c),
        .fim_off       (fim_off_c),
        .fim_tmo       (fim_tmo_c),
        .estado        (estado),
        .prox_estado_c (prox_c)
    );

    // Status flags for the FSM
    always_comb begin
        limite_c      = (modo == MODO_DEMO) ? RW'(RODADAS_DEMO) : RW'(MAX_RODADAS);
        press_unico_c = $onehot(press_val_q);
        acertou_c     = $onehot(jogada) && (codifica(jogada) == mem[endereco]);
        fim_seq_c     = (RW'(endereco) == rodada - RW'(1));
        ultima_c      = (rodada == limite_c);
        escrita_c     = (modo == MODO_ESCRITA);
        fim_on_c      = (tmr == TW'(LED_ON - 1));
        fim_off_c     = (tmr == TW'(LED_OFF - 1));
        fim_tmo_c     = (tmr == TW'(TIMEOUT_CICLOS - 1)) && (modo != MODO_SEM_TIMEOUT);
    end

    // Counter updates driven by the state being left
    always_comb begin
        endereco_prox_c = endereco;
        rodada_prox_c   = rodada;
        case (estado)
            PREPARA: begin
                endereco_prox_c = '0;
                rodada_prox_c   = RW'(1);
            end
            PROX_LED:    endereco_prox_c = (prox_c == MOSTRA_LED) ? endereco + AW'(1) : '0;
            PROX_JOGADA: endereco_prox_c = endereco + AW'(1);
            PROX_RODADA: begin
                endereco_prox_c = '0;
                rodada_prox_c   = rodada + RW'(1);
            end
            default: ;
        endcase
    end

    // Sequence memory; reset restores the built-in pattern and aborts writes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(MAX_RODADAS); i++)
                mem[i] <= BW'((3 * i + 1) % int'(N_BOTOES));
        end else if (estado == ESCRITA && press_q && press_unico_c) begin
            mem[AW'(rodada)] <= codifica(press_val_q);
        end
    end

    // Datapath registers and Moore outputs loaded from the next state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            modo        <= MODO_NORMAL;
            rodada      <= '0;
            endereco    <= '0;
            botoes_q    <= '0;
            press_val_q <= '0;
            press_q     <= 1'b0;
            jogada      <= '0;
            tmr         <= '0;
            leds_q      <= '0;
            pronto_q    <= 1'b0;
            ganhou_q    <= 1'b0;
            perdeu_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            if (prox_c == PREPARA) modo <= bus.configuracao;
            rodada      <= rodada_prox_c;
            endereco    <= endereco_prox_c;
            botoes_q    <= bus.botoes;
            press_val_q <= bus.botoes;
            press_q     <= (|bus.botoes) & ~(|botoes_q);
            if (estado == ESPERA_JOGADA && press_q) jogada <= press_val_q;
            // Shared timer restarts on every state change (and so on every accepted press)
            tmr         <= (prox_c != estado) ? '0 : tmr + TW'(1);
            if (prox_c == MOSTRA_LED)
                leds_q <= N_BOTOES'(1) << mem[endereco_prox_c];
            else if (prox_c == ESCRITA && escrita_c)
                leds_q <= bus.botoes;
            else
                leds_q <= '0;
            pronto_q  <= (prox_c == FIM_GANHOU) || (prox_c == FIM_PERDEU) || (prox_c == FIM_TIMEOUT);
            ganhou_q  <= (prox_c == FIM_GANHOU);
            perdeu_q  <= (prox_c == FIM_PERDEU) || (prox_c == FIM_TIMEOUT);
            timeout_q <= (prox_c == FIM_TIMEOUT);
        end
    end

    assign bus.leds      = leds_q;
    assign bus.pronto    = pronto_q;
    assign bus.ganhou    = ganhou_q;
    assign bus.perdeu    = perdeu_q;
    assign bus.timeout   = timeout_q;
    assign bus.db_estado = estado;
    assign bus.db_rodada = rodada;
    assign bus.db_modo   = modo;

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Directed self-checking bench for jogo_memoria_param (N=4, 16 rounds, short LED timing).
module tb_jogo_memoria_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vetores = 0;
    int   erros = 0;
    int   vis [16];
    int   n_vis;
    int   esp [16] = '{1, 0, 3, 2, 1, 0, 3, 2, 1, 0, 3, 2, 1, 0, 3, 2};
    int   tk;

    always #5 clk = ~clk;

    jogo_memoria_param_if #(.N_BOTOES(4), .MAX_RODADAS(16)) bus ();

    jogo_memoria_param #(
        .N_BOTOES(4), .MAX_RODADAS(16), .RODADAS_DEMO(4),
        .LED_ON(8), .LED_OFF(4), .TIMEOUT_CICLOS(5000)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vetores++;
        assert (obs === exp) else begin
            erros++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic inicia(input logic [1:0] cfg);
        @(negedge clk);
        bus.configuracao = cfg;
        bus.jogar = 1'b1;
        @(negedge clk);
        bus.jogar = 1'b0;
    endtask

    task automatic aperta(input logic [3:0] b);
        @(negedge clk);
        bus.botoes = b;
        repeat (2) @(negedge clk);
        bus.botoes = '0;
        repeat (2) @(negedge clk);
    endtask

    // Record each LED lit until the game starts waiting for the player
    task automatic assistir();
        logic [3:0] prev;
        logic       ok;
        prev  = '0;
        ok    = 1'b0;
        n_vis = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (bus.leds != 0 && prev == 0 && n_vis < 16) begin
                for (int j = 0; j < 4; j++) if (bus.leds[j]) vis[n_vis] = j;
                n_vis++;
            end
            prev = bus.leds;
            if (bus.db_estado == 5'd5) begin
                ok = 1'b1;
                break;
            end
        end
        chk("espera_jogada_alcancada", 32'(ok), 32'd1);
    endtask

    // Play n rounds of the default pattern, checking each shown sequence
    task automatic rodadas(input int n);
        logic ok;
        for (int r = 1; r <= n; r++) begin
            assistir();
            ok = (n_vis == r);
            for (int i = 0; i < r && i < n_vis; i++) if (vis[i] != esp[i]) ok = 1'b0;
            chk($sformatf("seq_rodada_%0d", r), 32'(ok), 32'd1);
            for (int i = 0; i < r; i++) aperta(4'(1 << esp[i]));
        end
    endtask

    initial begin
        bus.jogar = 1'b0;
        bus.configuracao = 2'b00;
        bus.botoes = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_leds", 32'(bus.leds), 32'd0);
        chk("rst_flags", 32'({bus.pronto, bus.ganhou, bus.perdeu, bus.timeout}), 32'd0);
        chk("rst_estado", 32'(bus.db_estado), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("pos_rst_estado", 32'(bus.db_estado), 32'd0);

        // Demo mode, configuracao changed mid-game must be ignored
        inicia(2'b01);
        chk("jogar_lat1_estado", 32'(bus.db_estado), 32'd1);
        chk("jogar_lat1_leds", 32'(bus.leds), 32'd0);
        @(negedge clk);
        chk("jogar_lat2_estado", 32'(bus.db_estado), 32'd2);
        chk("jogar_lat2_leds", 32'(bus.leds), 32'b0010);
        bus.configuracao = 2'b00;
        rodadas(4);
        chk("demo_modo", 32'(bus.db_modo), 32'd1);
        chk("demo_estado", 32'(bus.db_estado), 32'd10);
        chk("demo_ganhou_pronto", 32'({bus.ganhou, bus.pronto, bus.perdeu}), 32'b110);
        chk("demo_rodada", 32'(bus.db_rodada), 32'd4);

        // Normal mode, full 16 rounds
        inicia(2'b00);
        rodadas(16);
        chk("normal_estado", 32'(bus.db_estado), 32'd10);
        chk("normal_ganhou", 32'({bus.ganhou, bus.pronto, bus.perdeu, bus.timeout}), 32'b1100);
        chk("normal_rodada", 32'(bus.db_rodada), 32'd16);
        chk("normal_modo", 32'(bus.db_modo), 32'd0);

        // Wrong second press in round 2
        inicia(2'b00);
        rodadas(1);
        assistir();
        chk("errado_seq_n", 32'(n_vis), 32'd2);
        aperta(4'b0010);
        aperta(4'b1000);
        chk("errado_estado", 32'(bus.db_estado), 32'd11);
        chk("errado_flags", 32'({bus.pronto, bus.ganhou, bus.perdeu, bus.timeout}), 32'b1010);

        // Timeout after exactly TIMEOUT_CICLOS idle cycles
        inicia(2'b00);
        assistir();
        tk = 0;
        for (int k = 1; k <= 6000; k++) begin
            @(negedge clk);
            if (bus.pronto) begin
                tk = k;
                break;
            end
        end
        chk("timeout_ciclos", 32'(tk), 32'd5000);
        chk("timeout_estado", 32'(bus.db_estado), 32'd12);
        chk("timeout_flags", 32'({bus.pronto, bus.ganhou, bus.perdeu, bus.timeout}), 32'b1011);

        // Mode 10: no timeout, then lose with a wrong press
        inicia(2'b10);
        assistir();
        repeat (5100) @(negedge clk);
        chk("sem_tmo_estado", 32'(bus.db_estado), 32'd5);
        chk("sem_tmo_pronto", 32'(bus.pronto), 32'd0);
        chk("sem_tmo_modo", 32'(bus.db_modo), 32'd2);
        aperta(4'b1000);
        chk("sem_tmo_perdeu", 32'(bus.db_estado), 32'd11);

        // Escrita mode: append 2, then 3
        inicia(2'b11);
        assistir();
        chk("escr_r1", 32'({n_vis[3:0], 4'(vis[0])}), 32'h11);
        aperta(4'b0010);
        chk("escr_estado", 32'(bus.db_estado), 32'd8);
        @(negedge clk);
        bus.botoes = 4'b0100;
        @(negedge clk);
        chk("escr_eco_leds", 32'(bus.leds), 32'b0100);
        @(negedge clk);
        bus.botoes = '0;
        assistir();
        chk("escr_r2", 32'({n_vis[3:0], 4'(vis[0]), 4'(vis[1])}), 32'h212);
        aperta(4'b0010);
        aperta(4'b0100);
        chk("escr_estado2", 32'(bus.db_estado), 32'd8);
        aperta(4'b1000);
        assistir();
        chk("escr_r3", 32'({n_vis[3:0], 4'(vis[0]), 4'(vis[1]), 4'(vis[2])}), 32'h3123);
        aperta(4'b0010);
        aperta(4'b0100);
        aperta(4'b1000);
        aperta(4'b0011);
        chk("escr_multi_estado", 32'(bus.db_estado), 32'd11);
        chk("escr_multi_perdeu", 32'({bus.perdeu, bus.timeout}), 32'b10);

        // Written entries persist into the next game; multi-button press loses
        inicia(2'b00);
        assistir();
        aperta(4'b0010);
        assistir();
        chk("persist_r2", 32'({n_vis[3:0], 4'(vis[0]), 4'(vis[1])}), 32'h212);
        aperta(4'b0010);
        aperta(4'b0100);
        assistir();
        chk("persist_r3", 32'({n_vis[3:0], 4'(vis[0]), 4'(vis[1]), 4'(vis[2])}), 32'h3123);
        aperta(4'b0010);
        aperta(4'b0101);
        chk("multi_estado", 32'(bus.db_estado), 32'd11);
        chk("multi_perdeu", 32'(bus.perdeu), 32'd1);

        // Asynchronous reset in the middle of MOSTRA_LED
        inicia(2'b01);
        @(posedge clk);
        #2;
        chk("pre_rst_estado", 32'(bus.db_estado), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("async_rst_leds", 32'(bus.leds), 32'd0);
        chk("async_rst_estado", 32'(bus.db_estado), 32'd0);
        chk("async_rst_resto", 32'({bus.pronto, bus.ganhou, bus.perdeu, bus.timeout, bus.db_rodada, bus.db_modo}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Memory pattern restored by reset
        inicia(2'b00);
        rodadas(2);

        $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
        $finish;
    end

endmodule
